qmem_arbiter: RTL and testbench
===============================

// Module: qmem_arbiter
// PURPOSE
//  - Shares one qmem slave port between MN qmem masters (e.g. CPU data, CPU insn, debug/DMA).
//  - Registered round-robin arbitration: one transfer granted at a time, held until slave ack/err.
//  - Sits upstream of the qmem address decoder; its slave-side port drives the decoder's master input.
// PARAMETERS
//  - QAW  32      address width
//  - QDW  32      data width
//  - QSW  QDW/8   byte-select width
//  - MN   2       number of masters, 2..8
//  - TOW  8       timeout counter width; timeout after 2**TOW-1 cycles (only with QMEM_ARB_TIMEOUT_EN)
// PORTS
//  - clk       in   1        system clock, all state on rising edge
//  - rst_n     in   1        asynchronous active-low reset
//  - qm_cs     in   MN       per-master chip select, held until that master's ack/err
//  - qm_we     in   MN       per-master write enable
//  - qm_adr    in   MN*QAW   per-master address, master i at [QAW*i +: QAW]
//  - qm_sel    in   MN*QSW   per-master byte selects
//  - qm_dat_w  in   MN*QDW   per-master write data
//  - qm_dat_r  out  MN*QDW   read data, qs_dat_r broadcast to every master slot
//  - qm_ack    out  MN       per-master ack
//  - qm_err    out  MN       per-master error
//  - qs_cs/qs_we  out  1     to slave
//  - qs_adr/qs_sel/qs_dat_w  out  QAW/QSW/QDW  muxed from granted master
//  - qs_dat_r  in   QDW      slave read data, valid cycle after read ack
//  - qs_ack/qs_err  in  1    slave ack/error
//  - gnt       out  MN       one-hot current grant (debug/observability)
// BEHAVIOUR
//  - Reset: state IDLE, gnt=0, last pointer=MN-1, all qs_* outputs 0, qm_ack=qm_err=0.
//  - FSM IDLE: if |qm_cs, pick winner round-robin starting at (last+1) mod MN; register gnt, last<=winner; -> BUSY.
//  - FSM BUSY: qs_* = granted master's signals, qs_cs = qm_cs[g]; qm_ack[g]=qs_ack, qm_err[g]=qs_err (comb).
//  - BUSY -> IDLE on qs_ack|qs_err; gnt cleared same edge. One-cycle IDLE bubble between grants (fixed).
//  - Latency: first qs_cs one cycle after qm_cs rises; ack passes through combinationally, zero added.
//  - Non-granted masters: qm_ack=qm_err=0, their cs ignored until granted.
//  - Master drops qm_cs[g] in BUSY before ack: abort, qs_cs deasserts same cycle, -> IDLE, nothing forwarded.
//  - qs_ack and qs_err together: both forwarded; single transfer completion.
//  - Ungranted state (IDLE): qs_cs=0, qs_adr/sel/dat_w/we = 0.
//  - Read data: qm_dat_r = qs_dat_r for all slots; only the master acked last cycle may sample it.
//  - Round-robin fairness: with all MN requesting, each granted once per MN transfers; no starvation.
//  - rst_n asserted mid-transfer: immediate IDLE, qs_cs drops asynchronously; transfer lost.
// CONFIGURATION
//  - Macro QMEM_ARB_TIMEOUT_EN defined: counter cleared on entering BUSY, increments each BUSY cycle;
//    at 2**TOW-1 without ack/err: qm_err[g]=1 for one cycle, qs_cs=0, -> IDLE.
//  - Not defined: no counter, BUSY waits indefinitely for qs_ack/qs_err; TOW unused.
// STRUCTURE
//  - Shared package qmem_pkg: QAW/QDW/QSW defaults, FSM state encodings (ST_IDLE, ST_BUSY), MN_MAX=8.
//  - Sub-module qmem_arb_rr: combinational round-robin picker (req[MN], last index -> one-hot win, index).
//  - Top holds FSM, grant/last registers, optional timeout counter, slave-side mux.
// TESTING
//  - Single master: m0 read adr 0x100, slave acks 2 cycles later -> qs_cs one cycle after qm_cs[0], qm_ack[0] only.
//  - MN=2, both cs same cycle from reset -> m0 granted first, then m1 after m0 ack; third pair grants m0 again.
//  - MN=4 all requesting continuously, 0-wait slave -> grant order 0,1,2,3,0 with one IDLE cycle between.
//  - Master 1 drops cs in BUSY before ack -> qs_cs falls same cycle, no qm_ack[1], next requester granted.
//  - Slave asserts qs_err on m0 write 0xDEADBEEF -> qm_err[0]=1, qm_ack=0, FSM back to IDLE.
//  - QMEM_ARB_TIMEOUT_EN, TOW=4, slave silent -> qm_err[g] pulses at BUSY cycle 15; rst_n low mid-BUSY -> gnt=0 immediately.

Source files
------------

// File: rtl/qmem_pkg.sv
// Shared qmem definitions: default bus widths, arbiter FSM state encoding,
// and the largest supported master count.
package qmem_pkg;

   localparam int QAW_DEF = 32;
   localparam int QDW_DEF = 32;
   localparam int QSW_DEF = QDW_DEF / 8;
   localparam int MN_MAX  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/qmem_arb_rr.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping modulo MN) wins. Outputs both a one-hot vector and an index.
module qmem_arb_rr
   import qmem_pkg::*;
#(
   parameter int MN = 2,
   parameter int IW = 1
)(
   input  logic [MN-1:0] req,
   input  logic [IW-1:0] last,
   output logic [MN-1:0] win,
   output logic [IW-1:0] win_idx
);

   // Scan farthest-to-nearest so the nearest requester after 'last' is written last and wins
   always_comb begin
      int idx;
      win     = '0;
      win_idx = '0;
      idx     = 0;
      for (int k = MN; k >= 1; k--) begin
         idx = (int'(last) + k) % MN;
         if (req[idx]) begin
            win      = '0;
            win[idx] = 1'b1;
            win_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/qmem_arbiter.sv
// qmem round-robin arbiter: MN masters share one qmem slave port.
// One transfer is granted at a time and held until the slave acks or errors;
// a single IDLE cycle separates consecutive grants.
// Optional watchdog: define QMEM_ARB_TIMEOUT_EN to terminate a transfer with
// an error after 2**TOW-1 BUSY cycles without slave ack/err.
module qmem_arbiter
   import qmem_pkg::*;
#(
   parameter int QAW = QAW_DEF,
   parameter int QDW = QDW_DEF,
   parameter int QSW = QDW / 8,
   parameter int MN  = 2,
   parameter int TOW = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MN-1:0]     qm_cs,
   input  logic [MN-1:0]     qm_we,
   input  logic [MN*QAW-1:0] qm_adr,
   input  logic [MN*QSW-1:0] qm_sel,
   input  logic [MN*QDW-1:0] qm_dat_w,
   output logic [MN*QDW-1:0] qm_dat_r,
   output logic [MN-1:0]     qm_ack,
   output logic [MN-1:0]     qm_err,
   output logic              qs_cs,
   output logic              qs_we,
   output logic [QAW-1:0]    qs_adr,
   output logic [QSW-1:0]    qs_sel,
   output logic [QDW-1:0]    qs_dat_w,
   input  logic [QDW-1:0]    qs_dat_r,
   input  logic              qs_ack,
   input  logic              qs_err,
   output logic [MN-1:0]     gnt
);

   localparam int IW = (MN > 1) ? $clog2(MN) : 1;

   arb_state_t    state_q, state_d;
   logic [MN-1:0] gnt_q, gnt_d;
   logic [IW-1:0] gidx_q, gidx_d;
   logic [IW-1:0] last_q, last_d;
   logic [MN-1:0] win;
   logic [IW-1:0] win_idx;
   logic          tmo;
   logic          done;

   qmem_arb_rr #(.MN(MN), .IW(IW)) u_rr (
      .req     (qm_cs),
      .last    (last_q),
      .win     (win),
      .win_idx (win_idx)
   );

`ifdef QMEM_ARB_TIMEOUT_EN
   logic [TOW-1:0] cnt_q, cnt_d;

   // Watchdog counts BUSY cycles; held at zero in IDLE so each grant starts fresh
   always_comb cnt_d = (state_q == ST_BUSY) ? cnt_q + 1'b1 : '0;

   // Watchdog counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tmo = (state_q == ST_BUSY) && (&cnt_q);
`else
   // No watchdog in this build: BUSY waits for the slave indefinitely
   assign tmo = (TOW < 0);
`endif

   // Read data is broadcast; only the master acked last cycle samples it
   assign qm_dat_r = {MN{qs_dat_r}};
   assign gnt      = gnt_q;

   // Next-state, grant bookkeeping and slave-side mux
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gidx_d   = gidx_q;
      last_d   = last_q;
      done     = 1'b0;
      qs_cs    = 1'b0;
      qs_we    = 1'b0;
      qs_adr   = '0;
      qs_sel   = '0;
      qs_dat_w = '0;
      qm_ack   = '0;
      qm_err   = '0;
      case (state_q)
         ST_IDLE: begin
            if (|qm_cs) begin
               state_d = ST_BUSY;
               gnt_d   = win;
               gidx_d  = win_idx;
               last_d  = win_idx;
            end
         end
         ST_BUSY: begin
            qs_we    = qm_we[gidx_q];
            qs_adr   = qm_adr[QAW*int'(gidx_q) +: QAW];
            qs_sel   = qm_sel[QSW*int'(gidx_q) +: QSW];
            qs_dat_w = qm_dat_w[QDW*int'(gidx_q) +: QDW];
            if (!qm_cs[gidx_q]) begin
               // Master withdrew before completion: abort silently
               done = 1'b1;
            end else begin
               // cs drops on timeout so the slave cannot complete a late ack
               qs_cs          = ~tmo;
               qm_ack[gidx_q] = qs_ack;
               qm_err[gidx_q] = qs_err | (tmo & ~qs_ack);
               done           = qs_ack | qs_err | tmo;
            end
            if (done) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(MN - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_qmem_arbiter.sv
// Directed bench for qmem_arbiter with four masters.
module tb_qmem_arbiter;

   localparam int QAW = 32;
   localparam int QDW = 32;
   localparam int QSW = 4;
   localparam int MN  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [MN-1:0]     qm_cs;
   logic [MN-1:0]     qm_we;
   logic [MN*QAW-1:0] qm_adr;
   logic [MN*QSW-1:0] qm_sel;
   logic [MN*QDW-1:0] qm_dat_w;
   logic [MN*QDW-1:0] qm_dat_r;
   logic [MN-1:0]     qm_ack;
   logic [MN-1:0]     qm_err;
   logic              qs_cs;
   logic              qs_we;
   logic [QAW-1:0]    qs_adr;
   logic [QSW-1:0]    qs_sel;
   logic [QDW-1:0]    qs_dat_w;
   logic [QDW-1:0]    qs_dat_r;
   logic              qs_ack;
   logic              qs_err;
   logic [MN-1:0]     gnt;

   int errs   = 0;
   int checks = 0;

   qmem_arbiter #(.QAW(QAW), .QDW(QDW), .QSW(QSW), .MN(MN), .TOW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .qm_cs    (qm_cs),
      .qm_we    (qm_we),
      .qm_adr   (qm_adr),
      .qm_sel   (qm_sel),
      .qm_dat_w (qm_dat_w),
      .qm_dat_r (qm_dat_r),
      .qm_ack   (qm_ack),
      .qm_err   (qm_err),
      .qs_cs    (qs_cs),
      .qs_we    (qs_we),
      .qs_adr   (qs_adr),
      .qs_sel   (qs_sel),
      .qs_dat_w (qs_dat_w),
      .qs_dat_r (qs_dat_r),
      .qs_ack   (qs_ack),
      .qs_err   (qs_err),
      .gnt      (gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; inputs change here, checks follow after #1
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_m(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
      qm_we[i]            = we;
      qm_adr[32*i +: 32]  = adr;
      qm_dat_w[32*i +: 32] = dat;
      qm_sel[4*i +: 4]    = 4'hF;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      qm_cs    = '0;
      qm_we    = '0;
      qm_adr   = '0;
      qm_sel   = '0;
      qm_dat_w = '0;
      qs_dat_r = '0;
      qs_ack   = 1'b0;
      qs_err   = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_qs_cs", qs_cs, 0);
      chk("rst_ack", qm_ack, 0);
      chk("rst_err", qm_err, 0);
      chk("rst_adr", qs_adr, 0);

      // Single master read of 0x100, slave acks on the third BUSY cycle
      cyc(); set_m(0, 1'b0, 32'h100, 32'h0); qm_cs = 4'b0001; #1;
      chk("t1_cs_latency", qs_cs, 0);
      cyc(); #1;
      chk("t1_gnt", gnt, 4'b0001);
      chk("t1_qs_cs", qs_cs, 1);
      chk("t1_adr", qs_adr, 32'h100);
      chk("t1_we", qs_we, 0);
      chk("t1_sel", qs_sel, 4'hF);
      chk("t1_noack", qm_ack, 0);
      cyc(); #1;
      chk("t1_wait_cs", qs_cs, 1);
      cyc(); qs_ack = 1'b1; #1;
      chk("t1_ack", qm_ack, 4'b0001);
      chk("t1_err", qm_err, 0);
      cyc(); qs_ack = 1'b0; qm_cs = '0; qs_dat_r = 32'h1234_5678; #1;
      chk("t1_idle_gnt", gnt, 0);
      chk("t1_idle_cs", qs_cs, 0);
      chk("t1_idle_adr", qs_adr, 0);
      chk("t1_dat_r0", qm_dat_r[31:0], 32'h1234_5678);
      chk("t1_dat_r3", qm_dat_r[127:96], 32'h1234_5678);

      // Two masters requesting together from reset
      do_reset();
      set_m(0, 1'b0, 32'h200, 32'h0);
      set_m(1, 1'b1, 32'h300, 32'hA5);
      qm_cs = 4'b0011; #1;
      chk("t2_idle0", gnt, 0);
      cyc(); qs_ack = 1'b1; #1;
      chk("t2_gnt_m0", gnt, 4'b0001);
      chk("t2_adr_m0", qs_adr, 32'h200);
      chk("t2_ack_m0", qm_ack, 4'b0001);
      cyc(); qs_ack = 1'b0; qm_cs = 4'b0010; #1;
      chk("t2_bubble", gnt, 0);
      cyc(); qs_ack = 1'b1; #1;
      chk("t2_gnt_m1", gnt, 4'b0010);
      chk("t2_adr_m1", qs_adr, 32'h300);
      chk("t2_we_m1", qs_we, 1);
      chk("t2_dat_m1", qs_dat_w, 32'hA5);
      chk("t2_ack_m1", qm_ack, 4'b0010);
      cyc(); qs_ack = 1'b0; qm_cs = 4'b0011; #1;
      chk("t2_bubble2", gnt, 0);
      cyc(); #1;
      chk("t2_pair3_m0", gnt, 4'b0001);
      cyc(); qs_ack = 1'b1; #1;
      chk("t2_pair3_ack", qm_ack, 4'b0001);
      cyc(); qs_ack = 1'b0; qm_cs = '0;

      // Four masters requesting continuously against a zero-wait slave
      do_reset();
      for (int i = 0; i < MN; i++) set_m(i, 1'b0, 32'h1000 + 32'(i), 32'h0);
      qm_cs  = 4'b1111;
      qs_ack = 1'b1; #1;
      chk("t3_idle_start", gnt, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(); #1;
         chk($sformatf("t3_gnt%0d", i), gnt, 4'b0001 << (i % 4));
         chk($sformatf("t3_ack%0d", i), qm_ack, 4'b0001 << (i % 4));
         chk($sformatf("t3_adr%0d", i), qs_adr, 32'h1000 + 32'(i % 4));
         cyc(); #1;
         chk($sformatf("t3_bubble%0d", i), gnt, 0);
         chk($sformatf("t3_bub_ack%0d", i), qm_ack, 0);
      end
      qs_ack = 1'b0; qm_cs = '0;

      // Master 1 withdraws mid-transfer, master 2 is served next
      do_reset();
      qm_cs = 4'b0110; #1;
      cyc(); #1;
      chk("t4_gnt_m1", gnt, 4'b0010);
      chk("t4_cs_m1", qs_cs, 1);
      cyc(); qm_cs = 4'b0100; #1;
      chk("t4_abort_cs", qs_cs, 0);
      chk("t4_abort_ack", qm_ack, 0);
      cyc(); #1;
      chk("t4_abort_idle", gnt, 0);
      cyc(); qs_ack = 1'b1; #1;
      chk("t4_gnt_m2", gnt, 4'b0100);
      chk("t4_ack_m2", qm_ack, 4'b0100);
      cyc(); qs_ack = 1'b0; qm_cs = '0;

      // Slave error on a master 0 write
      do_reset();
      set_m(0, 1'b1, 32'h40, 32'hDEAD_BEEF);
      qm_cs = 4'b0001;
      cyc(); qs_err = 1'b1; #1;
      chk("t5_we", qs_we, 1);
      chk("t5_dat", qs_dat_w, 32'hDEAD_BEEF);
      chk("t5_err", qm_err, 4'b0001);
      chk("t5_noack", qm_ack, 0);
      cyc(); qs_err = 1'b0; qm_cs = '0; #1;
      chk("t5_idle", gnt, 0);
      chk("t5_err_clr", qm_err, 0);

`ifdef QMEM_ARB_TIMEOUT_EN
      // Silent slave: watchdog errors out on BUSY cycle 15
      do_reset();
      qm_cs = 4'b0001;
      for (int k = 0; k < 15; k++) begin
         cyc(); #1;
         chk($sformatf("t7_wait%0d", k), qm_err, 0);
      end
      cyc(); #1;
      chk("t7_tmo_err", qm_err, 4'b0001);
      chk("t7_tmo_cs", qs_cs, 0);
      cyc(); qm_cs = '0; #1;
      chk("t7_tmo_idle", gnt, 0);
`endif

      // Asynchronous reset in the middle of a transfer
      do_reset();
      qm_cs = 4'b0100;
      cyc(); #1;
      chk("t6_busy", gnt, 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_gnt", gnt, 0);
      chk("t6_async_cs", qs_cs, 0);
      cyc(); rst_n = 1'b1; qm_cs = '0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
